afifo_word_packer: RTL
======================

# afifo_word_packer

Read-side consumer of the JTAG asynchronous FIFO. Runs in the FIFO read-clock domain, pops bytes from the FIFO read port and packs them little-endian into bus-width words. Each word is handed downstream on a valid/ready handshake. Partial words are emitted on an explicit flush or after an idle timeout, so a short JTAG transfer is never stranded.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO byte width; must match the FIFO's DATA_WIDTH.
- WORD_BYTES, 4, bytes per output word; must be ≥2.
- TIMEOUT, 16, idle cycles before a partial word is forced out; must be ≥1.

Ports:
- CLK  in  1  read-domain clock; connects to the FIFO rclk.
- nRST  in  1  asynchronous active-low reset; connects to the FIFO r_nrst.
- fifo_rdata  in  DATA_WIDTH  FIFO head byte; valid whenever fifo_empty=0 (first-word fall-through).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rinc  out  1  pop strobe; one byte is consumed per cycle it is high.
- flush  in  1  force out the current partial word.
- word_data  out  DATA_WIDTH*WORD_BYTES  packed word; byte k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- word_nbytes  out  $clog2(WORD_BYTES+1)  count of valid bytes in word_data, from 1 to WORD_BYTES.
- word_valid  out  1  word_data and word_nbytes are valid.
- word_ready  in  1  downstream accepts the word.

## Operation
- The block has two states, FILL and OUT. Reset state is FILL.
- Internal state: byte_cnt of width $clog2(WORD_BYTES+1), an assembly register, and an idle counter of width $clog2(TIMEOUT+1).

FILL state:
- fifo_rinc = !fifo_empty && !flush.
- On a pop, fifo_rdata is written into lane byte_cnt and byte_cnt increments.
- If that pop fills lane WORD_BYTES-1, the next state is OUT with word_nbytes=WORD_BYTES.
- Idle counter:
  - Clears on every pop and whenever byte_cnt=0.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT, the next state is OUT with word_nbytes=byte_cnt.
- flush with byte_cnt>0: the next state is OUT with word_nbytes=byte_cnt, and no pop occurs that cycle.
- flush with byte_cnt=0: no effect beyond suppressing the pop.
- Flush, timeout and a completing pop never coincide, because flush gates the pop. Timeout and flush together give the same result.

OUT state:
- word_valid=1 and fifo_rinc=0.
- Unfilled lanes of word_data read 0.
- word_data and word_nbytes stay stable until the handshake.
- flush is ignored.
- On word_valid && word_ready: lanes, byte_cnt and the idle counter all clear, and the next state is FILL.

Reset:
- nRST low at any time, including mid-word or mid-handshake, discards partial data.
- Reset values: word_valid=0, word_data=0, word_nbytes=0, fifo_rinc=0, state FILL.

## Timing
- fifo_rinc is combinational from state, fifo_empty and flush only. There is no path from fifo_rdata or word_ready.
- word_data, word_valid and word_nbytes are registered.
- Latency: the final byte is popped at edge N and word_valid is high after edge N. With word_ready held high, the word is accepted at edge N+1.
- word_ready is combinationally ignored outside OUT.
- Peak throughput is WORD_BYTES pops plus one OUT cycle per word, i.e. 5 cycles per 32-bit word with the default parameters.
- Timeout: with the last pop at edge P and no further data, the idle counter reaches TIMEOUT at edge P+TIMEOUT, and word_valid rises after the following edge.
- Backpressure: word_ready held low stalls indefinitely with no pops. FIFO fullness is the upstream's concern.

## Test plan
- **Full word:** push bytes 0x11,0x22,0x33,0x44 with word_ready=1.
  - Expect word_data=0x44332211 and word_nbytes=4.
  - Expect exactly 4 fifo_rinc pulses and word_valid for 1 cycle.
- **Backpressure:** as above, with word_ready=0 for 10 cycles while 0x55 waits in the FIFO.
  - Expect word_data stable and fifo_rinc=0 throughout.
  - After ready, 0x55 lands in lane 0 of the next word.
- **Flush:** push 0xAA,0xBB, then pulse flush.
  - Expect word_data=0x0000BBAA and word_nbytes=2.
  - A flush with byte_cnt=0 produces no word_valid.
- **Timeout:** push one byte 0x7E and leave the FIFO empty.
  - Expect word_valid=1 after TIMEOUT+1 cycles with word_nbytes=1 and word_data=0x0000007E.
  - With TIMEOUT=16, no word_valid appears before then.
- **Flush vs. pop:** flush asserted while fifo_empty=0 and byte_cnt=3.
  - Expect fifo_rinc=0 that cycle and word_nbytes=3.
  - The head byte is preserved for the next word.
- **Reset mid-operation:** assert nRST low while byte_cnt=2, and separately while in OUT.
  - Expect all outputs to read 0 immediately.
  - After release, the next word starts at lane 0.

Source files
------------

// File: rtl/afifo_word_packer.sv
// -----------------------------------------------------------------------------
// afifo_word_packer
//
// Read-side consumer of the JTAG asynchronous FIFO. Lives entirely in the FIFO
// read-clock domain. Bytes are popped from a first-word-fall-through FIFO read
// port and packed little-endian into WORD_BYTES-wide words, which are handed
// downstream on a valid/ready handshake. A partially filled word is pushed out
// either on an explicit flush or after TIMEOUT idle cycles, so a short JTAG
// transfer never sits stranded in the assembly register.
//
// Ports:
//   CLK          in   read-domain clock (FIFO rclk)
//   nRST         in   asynchronous active-low reset (FIFO r_nrst)
//   fifo_rdata   in   FIFO head byte, valid while fifo_empty is low
//   fifo_empty   in   FIFO empty flag
//   fifo_rinc    out  pop strobe, one byte consumed per high cycle
//   flush        in   force out the current partial word
//   word_data    out  packed word, byte k at [k*DATA_WIDTH +: DATA_WIDTH]
//   word_nbytes  out  number of valid bytes in word_data (1..WORD_BYTES)
//   word_valid   out  word_data / word_nbytes are valid
//   word_ready   in   downstream accepts the word
// -----------------------------------------------------------------------------
module afifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_BYTES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic [DATA_WIDTH-1:0]               fifo_rdata,
    input  logic                                fifo_empty,
    output logic                                fifo_rinc,
    input  logic                                flush,
    output logic [DATA_WIDTH*WORD_BYTES-1:0]    word_data,
    output logic [$clog2(WORD_BYTES+1)-1:0]     word_nbytes,
    output logic                                word_valid,
    input  logic                                word_ready
);

    localparam int CNT_W  = $clog2(WORD_BYTES + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam int WORD_W = DATA_WIDTH * WORD_BYTES;

    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(WORD_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);

    typedef enum logic {
        S_FILL = 1'b0,
        S_OUT  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [WORD_W-1:0]   asm_q, asm_d;
    logic [CNT_W-1:0]    nbytes_q, nbytes_d;

    // Shared decode used by both the FSM and the datapath.
    logic pop_w;        // a byte is consumed this cycle
    logic partial_w;    // assembly register holds at least one byte
    logic timeout_w;    // idle counter has expired on a partial word
    logic last_lane_w;  // the pop (if any) lands in the top lane
    logic handshake_w;  // downstream takes the presented word

    // Flush gates the pop, so a flush can never race a completing byte.
    assign pop_w       = (state_q == S_FILL) && !fifo_empty && !flush;
    assign partial_w   = (byte_cnt_q != '0);
    assign timeout_w   = partial_w && (idle_q == IDLE_MAX);
    assign last_lane_w = (byte_cnt_q == LAST_LANE);
    assign handshake_w = (state_q == S_OUT) && word_ready;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL: begin
                if (pop_w) begin
                    // A late byte arriving on the expiry cycle is folded into
                    // the outgoing word instead of being dropped.
                    if (last_lane_w || timeout_w) begin
                        state_d = S_OUT;
                    end
                end else if (partial_w && (flush || timeout_w)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (word_ready) begin
                    state_d = S_FILL;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // Held low during reset so the FIFO is never popped while the
        // packer is discarding state, even if the FIFO still holds data.
        fifo_rinc  = nRST && pop_w;
        word_valid = (state_q == S_OUT);
    end

    // -------------------------------------------------------------------------
    // Datapath: assembly register, byte counter, idle counter, byte count
    // -------------------------------------------------------------------------
    always_comb begin
        asm_d      = asm_q;
        byte_cnt_d = byte_cnt_q;
        idle_d     = idle_q;
        nbytes_d   = nbytes_q;

        if (state_q == S_FILL) begin
            if (pop_w) begin
                for (int k = 0; k < WORD_BYTES; k++) begin
                    if (byte_cnt_q == CNT_W'(k)) begin
                        asm_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rdata;
                    end
                end
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                idle_d     = '0;
                if (last_lane_w || timeout_w) begin
                    nbytes_d = byte_cnt_q + CNT_W'(1);
                end
            end else if (!partial_w) begin
                // Nothing to time out on an empty word.
                idle_d = '0;
            end else begin
                if (flush || timeout_w) begin
                    nbytes_d = byte_cnt_q;
                end
                // Saturate; the word leaves FILL at expiry anyway.
                if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
        end else if (handshake_w) begin
            // Clearing every lane here is what keeps unfilled lanes of the
            // next short word reading as zero.
            asm_d      = '0;
            byte_cnt_d = '0;
            idle_d     = '0;
            nbytes_d   = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            asm_q      <= '0;
            byte_cnt_q <= '0;
            idle_q     <= '0;
            nbytes_q   <= '0;
        end else begin
            asm_q      <= asm_d;
            byte_cnt_q <= byte_cnt_d;
            idle_q     <= idle_d;
            nbytes_q   <= nbytes_d;
        end
    end

    // The assembly register is only ever observed downstream while in OUT,
    // where its contents are frozen until the handshake.
    assign word_data   = asm_q;
    assign word_nbytes = nbytes_q;

endmodule
